param_alu: RTL and testbench
============================

// Module: param_alu
// PURPOSE
//  Parametrised ALU: add/sub/and/xor in one cycle, multiply through a MUL_STAGES-deep pipeline.
//  One start/done handshake and one shared result bus.
//  Registered busy output gates back-to-back issue.
//  Sits behind the test harness drivers as the DUT, or as a compute leaf in larger datapaths.
// PARAMETERS
//  WIDTH       8   operand width in bits (>=2); result is 2*WIDTH bits
//  MUL_STAGES  3   multiply latency in cycles from accept to done (>=1)
// PORTS
//  clk      in   1          clock, all state on rising edge
//  reset_n  in   1          reset, synchronous, active-low
//  start    in   1          issue request; sampled with op/A/B
//  op       in   3          000 nop, 001 add, 010 and, 011 xor, 100 mul, 101 sub, 11x illegal
//  A        in   WIDTH      operand A (unsigned)
//  B        in   WIDTH      operand B (unsigned)
//  busy     out  1          multiply in flight; start ignored while high
//  done     out  1          one-cycle pulse; result valid in same cycle
//  err      out  1          one-cycle pulse with done for illegal op
//  result   out  2*WIDTH    last completed result, held until next done
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): busy=0, done=0, err=0, result=0, pipeline flushed, FSM->IDLE.
//  - Reset mid-multiply: op aborted, no done ever issued for it.
//  - Accept: start=1 && busy=0 && op!=000 at edge T. Operands and op captured at T.
//  - start with op=000 is a no-op: no done, no err, result unchanged.
//  - start while busy=1 is silently dropped; no queueing.
//  - Single-cycle ops (001/010/011/101/11x): done=1 in cycle T+1; busy stays 0.
//  - Back-to-back single-cycle issue every cycle is legal.
//  - mul with MUL_STAGES=N:
//      busy=1 cycles T+1..T+N-1; done=1 and busy=0 in cycle T+N.
//      N=1 behaves exactly like a single-cycle op.
//  - A new start in the done cycle (busy=0) is accepted; full throughput = one mul per N cycles.
//  - FSM: IDLE --accept mul, N>1--> MUL_RUN (stage counter loads N-1).
//    MUL_RUN: counter decrements each cycle; at 1 -> IDLE with done pulse.
//    All other accepts stay in IDLE.
//  - Arithmetic, all into 2*WIDTH bits:
//      add: zero-extended A+B; carry lands in bit WIDTH.
//      sub: A-B as 2*WIDTH two's complement, i.e. wraps below zero, e.g. 0-1 = all ones.
//      and/xor: zero-extended.
//      mul: full unsigned product, no truncation.
//  - Illegal op (110/111): done=1 and err=1 at T+1; result forced to 0.
//  - result changes only in a done cycle; done never asserts without a prior accept.
// CONFIGURATION
//  PARAM_ALU_STATUS_EN defined:
//    - adds outputs zero (1) and neg (1), registered, updated only in done cycles, reset 0.
//    - zero = (result==0); neg = result[2*WIDTH-1] for sub, else 0.
//  PARAM_ALU_STATUS_EN undefined:
//    - ports zero/neg absent; no status logic.
// TESTING (WIDTH=8, MUL_STAGES=3 unless noted)
//  1. reset_n low 2 cycles during mul in flight
//     -> busy=0, done=0, result=0; no late done within 5 cycles.
//  2. add A=FF B=01 at T
//     -> done=1 at T+1, result=0x0100, busy=0 throughout.
//  3. mul A=FF B=FF at T, start again at T+1 (add 1+1)
//     -> second start dropped; busy=1 at T+1,T+2; done at T+3, result=0xFE01.
//  4. sub A=00 B=01
//     -> result=0xFFFF; with PARAM_ALU_STATUS_EN: neg=1, zero=0.
//  5. op=110 with start
//     -> done=1, err=1, result=0.
//     op=000 with start -> no done, result unchanged.
//  6. mul at T, mul at T+3 (done cycle), MUL_STAGES=1 rerun
//     -> second accepted, done at T+6; with N=1 done at T+1, busy never 1.

Source files
------------

// File: rtl/param_alu_if.sv
// Request/response bundle for param_alu. PARAM_ALU_STATUS_EN adds the zero/neg status outputs.
interface param_alu_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [2*WIDTH-1:0]   result;
`ifdef PARAM_ALU_STATUS_EN
  logic                 zero;
  logic                 neg;

  modport slave  (input  start, op, A, B, output busy, done, err, result, zero, neg);
  modport master (output start, op, A, B, input  busy, done, err, result, zero, neg);
`else
  modport slave  (input  start, op, A, B, output busy, done, err, result);
  modport master (output start, op, A, B, input  busy, done, err, result);
`endif
endinterface

// File: rtl/param_alu.sv
// Parametrised ALU: single-cycle add/sub/and/xor, multiply over MUL_STAGES cycles.
// Optional zero/neg status outputs under PARAM_ALU_STATUS_EN.
module param_alu #(
  parameter int WIDTH      = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  param_alu_if.slave  bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(MUL_STAGES + 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;
  logic [RW-1:0] r_result;

  logic [RW-1:0] w_a;
  logic [RW-1:0] w_b;
  logic [RW-1:0] w_prod;
  logic [RW-1:0] w_res;
  logic [RW-1:0] w_mul_out;
  logic          w_acc;
  logic          w_ill;
  logic          w_multi;

  assign w_a     = {{WIDTH{1'b0}}, bus.A};
  assign w_b     = {{WIDTH{1'b0}}, bus.B};
  assign w_prod  = w_a * w_b;
  assign w_acc   = bus.start && (r_state == S_IDLE) && (bus.op != OP_NOP);
  assign w_ill   = (bus.op[2:1] == 2'b11);
  // A one-stage multiply completes like any other single-cycle op.
  assign w_multi = (bus.op == OP_MUL) && (MUL_STAGES > 1);

  always_comb begin
    w_res = '0;
    case (bus.op)
      OP_ADD:  w_res = w_a + w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_MUL:  w_res = w_prod;
      OP_SUB:  w_res = w_a - w_b;
      default: w_res = '0;
    endcase
  end

  // Product pipeline: stage k holds the product k cycles after accept.
  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [MUL_STAGES-2:0][RW-1:0] r_pipe;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_pipe <= '0;
        end else begin
          if (w_acc && w_multi) r_pipe[0] <= w_prod;
          for (int i = 1; i < MUL_STAGES - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_mul_out = r_pipe[MUL_STAGES-2];
    end else begin : g_nopipe
      assign w_mul_out = w_prod;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_multi) begin
              r_state <= S_MUL_RUN;
              r_cnt   <= CW'(MUL_STAGES - 1);
            end else begin
              r_done   <= 1'b1;
              r_err    <= w_ill;
              r_result <= w_res;
            end
          end
        end
        S_MUL_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b1;
            r_result <= w_mul_out;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == S_MUL_RUN);
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.result = r_result;

`ifdef PARAM_ALU_STATUS_EN
  logic r_zero;
  logic r_neg;

  // Status tracks the value written to result in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_acc && !w_multi) begin
        r_zero <= (w_res == '0);
        r_neg  <= (bus.op == OP_SUB) && w_res[RW-1];
      end
    end else if (r_cnt == CW'(1)) begin
      r_zero <= (w_mul_out == '0);
      r_neg  <= 1'b0;
    end
  end

  assign bus.zero = r_zero;
  assign bus.neg  = r_neg;
`endif
endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu: vector table for single-cycle ops, hand sequences for multiply/reset.
module tb_param_alu;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  param_alu_if #(.WIDTH(8)) ifa ();
  param_alu_if #(.WIDTH(8)) ifb ();

  param_alu #(.WIDTH(8), .MUL_STAGES(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  param_alu #(.WIDTH(8), .MUL_STAGES(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
    logic        zero;
    logic        neg;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    ifa.start = s; ifa.op = op; ifa.A = a; ifa.B = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    ifb.start = 1'b0; ifb.op = 3'b000; ifb.A = 8'h00; ifb.B = 8'h00;

    vecs[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'b101, 8'h00, 8'h01, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'b110, 8'h12, 8'h34, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{3'b001, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3'b111, 8'hAA, 8'h55, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{3'b101, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   ifa.busy,   0);
    check("rst_done",   ifa.done,   0);
    check("rst_err",    ifa.err,    0);
    check("rst_result", ifa.result, 0);
`ifdef PARAM_ALU_STATUS_EN
    check("rst_zero", ifa.zero, 0);
    check("rst_neg",  ifa.neg,  0);
`endif
    reset_n = 1'b1;
    cyc();

    // Single-cycle ops issued back to back, one per cycle
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      cyc();
      check($sformatf("vec%0d_done", i),   ifa.done,   1);
      check($sformatf("vec%0d_result", i), ifa.result, {16'h0, vecs[i].res});
      check($sformatf("vec%0d_err", i),    ifa.err,    {31'h0, vecs[i].err});
      check($sformatf("vec%0d_busy", i),   ifa.busy,   0);
`ifdef PARAM_ALU_STATUS_EN
      check($sformatf("vec%0d_zero", i), ifa.zero, {31'h0, vecs[i].zero});
      check($sformatf("vec%0d_neg", i),  ifa.neg,  {31'h0, vecs[i].neg});
`endif
    end

    // nop start: no done, result held
    drive_a(1'b1, 3'b000, 8'h12, 8'h34);
    cyc();
    check("nop_done",   ifa.done,   0);
    check("nop_err",    ifa.err,    0);
    check("nop_result", ifa.result, 32'h007F);
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    cyc();
    check("idle_done", ifa.done, 0);

    // mul FF*FF, second start while busy is dropped
    drive_a(1'b1, 3'b100, 8'hFF, 8'hFF);
    cyc();
    check("mul1_busy_t1", ifa.busy, 1);
    check("mul1_done_t1", ifa.done, 0);
    drive_a(1'b1, 3'b001, 8'h01, 8'h01);
    cyc();
    check("mul1_busy_t2", ifa.busy, 1);
    check("mul1_done_t2", ifa.done, 0);
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    cyc();
    check("mul1_done_t3",   ifa.done,   1);
    check("mul1_busy_t3",   ifa.busy,   0);
    check("mul1_result_t3", ifa.result, 32'hFE01);
    check("mul1_err_t3",    ifa.err,    0);
`ifdef PARAM_ALU_STATUS_EN
    check("mul1_neg_t3",  ifa.neg,  0);
    check("mul1_zero_t3", ifa.zero, 0);
`endif
    cyc();
    check("mul1_drop_done", ifa.done,   0);
    check("mul1_drop_res",  ifa.result, 32'hFE01);

    // mul at T, mul accepted in its done cycle T+3, done at T+6
    drive_a(1'b1, 3'b100, 8'h02, 8'h03);
    cyc();
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    cyc();
    cyc();
    check("mul2_done_t3",   ifa.done,   1);
    check("mul2_result_t3", ifa.result, 32'h0006);
    drive_a(1'b1, 3'b100, 8'h04, 8'h05);
    cyc();
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    check("mul3_busy_t4", ifa.busy, 1);
    check("mul3_done_t4", ifa.done, 0);
    cyc();
    check("mul3_busy_t5", ifa.busy, 1);
    check("mul3_res_t5",  ifa.result, 32'h0006);
    cyc();
    check("mul3_done_t6",   ifa.done,   1);
    check("mul3_result_t6", ifa.result, 32'h0014);
    check("mul3_busy_t6",   ifa.busy,   0);

    // Reset while a mul is in flight aborts it
    drive_a(1'b1, 3'b100, 8'h07, 8'h07);
    cyc();
    drive_a(1'b0, 3'b000, 8'h00, 8'h00);
    check("abort_busy_pre", ifa.busy, 1);
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    check("abort_busy",   ifa.busy,   0);
    check("abort_done",   ifa.done,   0);
    check("abort_result", ifa.result, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("abort_late_done%0d", i), ifa.done, 0);
      check($sformatf("abort_late_res%0d", i),  ifa.result, 0);
    end

    // MUL_STAGES=1: mul completes next cycle, busy never rises
    ifb.start = 1'b1; ifb.op = 3'b100; ifb.A = 8'h10; ifb.B = 8'h10;
    cyc();
    check("n1_done0",   ifb.done,   1);
    check("n1_busy0",   ifb.busy,   0);
    check("n1_result0", ifb.result, 32'h0100);
    ifb.A = 8'h03; ifb.B = 8'h03;
    cyc();
    check("n1_done1",   ifb.done,   1);
    check("n1_busy1",   ifb.busy,   0);
    check("n1_result1", ifb.result, 32'h0009);
    ifb.start = 1'b0;
    cyc();
    check("n1_done2", ifb.done, 0);
    check("n1_busy2", ifb.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
